// File: rtl/cpu_pkg.sv
// Shared CPU-side types: program loader states, loader error codes and the
// instruction memory size.
package cpu_pkg;

   typedef enum logic [2:0] {
      L_IDLE,
      L_LEN_HI,
      L_LEN_LO,
      L_DATA,
      L_CSUM,
      L_DONE,
      L_ERR
   } loader_state_t;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_LEN  = 2'd1;
   localparam logic [1:0] ERR_CSUM = 2'd2;

   localparam int IMEM_BYTES = 1024;

   // States in which a frame is being received; these are also the only
   // states that accept stream bytes.
   function automatic logic in_frame(input loader_state_t s);
      return (s == L_LEN_HI) || (s == L_LEN_LO) || (s == L_DATA) || (s == L_CSUM);
   endfunction

endpackage

// File: rtl/imem_loader.sv
// Byte-stream program loader: writes a framed, XOR-checksummed image into the
// instruction memory byte port and holds the core in reset until it verifies.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// L_IDLE   | after reset, waiting for start
// L_LEN_HI | expecting word-count high byte
// L_LEN_LO | expecting word-count low byte, length range check
// L_DATA   | payload bytes, each written to memory one cycle later
// L_CSUM   | expecting the checksum byte
// L_DONE   | image loaded and verified, core released
// L_ERR    | length overflow or checksum mismatch, core held
module imem_loader
   import cpu_pkg::*;
#(
   parameter int MEM_BYTES = IMEM_BYTES,
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [15:0]       words_loaded,
   output logic              busy,
   output logic              done,
   output logic [1:0]        err_code,
   output logic              cpu_hold
);

   localparam logic [31:0]       ROOM     = 32'(MEM_BYTES - BASE_ADDR);
   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] IDX_STEP = ADDR_W'(1);

   loader_state_t     state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [7:0]        csum_q, csum_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic [15:0]       words_q, words_d;
   logic [1:0]        err_q, err_d;
   logic              ready_q, busy_q, done_q, hold_q;

   logic              accept;
   logic [15:0]       len_rx;
   logic [17:0]       bytes_rx;
   logic [17:0]       last_idx;

   assign accept   = byte_valid && ready_q;
   assign len_rx   = {len_q[15:8], byte_data};
   assign bytes_rx = {len_rx, 2'b00};
   assign last_idx = {len_q, 2'b00} - 18'd1;

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      idx_d     = idx_q;
      csum_d    = csum_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      words_d   = words_q;
      err_d     = err_q;

      unique case (state_q)
         L_IDLE, L_DONE, L_ERR: begin
            if (start) begin
               state_d = L_LEN_HI;
               idx_d   = '0;
               csum_d  = '0;
               words_d = '0;
               err_d   = ERR_NONE;
            end
         end
         L_LEN_HI: begin
            if (accept) begin
               len_d[15:8] = byte_data;
               csum_d      = csum_q ^ byte_data;
               state_d     = L_LEN_LO;
            end
         end
         L_LEN_LO: begin
            if (accept) begin
               len_d[7:0] = byte_data;
               csum_d     = csum_q ^ byte_data;
               if (len_rx == 16'd0) begin
                  state_d = L_CSUM;
               end else if ({14'd0, bytes_rx} > ROOM) begin
                  state_d = L_ERR;
                  err_d   = ERR_LEN;
               end else begin
                  state_d = L_DATA;
               end
            end
         end
         L_DATA: begin
            if (accept) begin
               wr_en_d   = 1'b1;
               wr_addr_d = BASE + idx_q;
               wr_data_d = byte_data;
               csum_d    = csum_q ^ byte_data;
               idx_d     = idx_q + IDX_STEP;
               if (idx_q[1:0] == 2'd3) begin
                  words_d = words_q + 16'd1;
               end
               if (32'(idx_q) == 32'(last_idx)) begin
                  state_d = L_CSUM;
               end
            end
         end
         L_CSUM: begin
            if (accept) begin
               if (byte_data == csum_q) begin
                  state_d = L_DONE;
               end else begin
                  state_d = L_ERR;
                  err_d   = ERR_CSUM;
               end
            end
         end
         default: state_d = L_IDLE;
      endcase
   end

   // Status outputs are registered decodes of the next state so that they
   // line up with state_q and never depend combinationally on byte_valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= L_IDLE;
         len_q     <= '0;
         idx_q     <= '0;
         csum_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         words_q   <= '0;
         err_q     <= ERR_NONE;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hold_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         csum_q    <= csum_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         words_q   <= words_d;
         err_q     <= err_d;
         ready_q   <= in_frame(state_d);
         busy_q    <= in_frame(state_d);
         done_q    <= (state_d == L_DONE);
         hold_q    <= (state_d != L_DONE);
      end
   end

   assign byte_ready   = ready_q;
   assign wr_en        = wr_en_q;
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;
   assign words_loaded = words_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err_code     = err_q;
   assign cpu_hold     = hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames from the test plan
// plus random frames checked against a frame-level reference model.
module tb_imem_loader;

   typedef logic [7:0] bq_t[$];

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready;
   logic        wr_en;
   logic [9:0]  wr_addr;
   logic [7:0]  wr_data;
   logic [15:0] words_loaded;
   logic        busy;
   logic        done;
   logic [1:0]  err_code;
   logic        cpu_hold;

   int tests_run = 0;
   int tests_failed = 0;
   int wr_cycles = 0;

   imem_loader #(.MEM_BYTES(1024), .ADDR_W(10), .BASE_ADDR(0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_ready(byte_ready), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .words_loaded(words_loaded),
      .busy(busy), .done(done), .err_code(err_code), .cpu_hold(cpu_hold)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (wr_en === 1'b1) wr_cycles++;

   // Frame-level reference: word count, expected error code, expected writes.
   function automatic void model(input bq_t fr, output int n, output int err, output int nwr);
      logic [7:0] x;
      n = {fr[0], fr[1]};
      if (4 * n > 1024) begin
         err = 1; nwr = 0;
      end else begin
         x = 8'h00;
         for (int i = 0; i < 2 + 4 * n; i++) x = x ^ fr[i];
         err = (fr[2 + 4 * n] == x) ? 0 : 2;
         nwr = 4 * n;
      end
   endfunction

   function automatic bq_t make_frame(input int n, input bit corrupt);
      bq_t fr;
      logic [7:0] x;
      logic [15:0] n16;
      n16 = 16'(n);
      fr.push_back(n16[15:8]);
      fr.push_back(n16[7:0]);
      for (int i = 0; i < 4 * n; i++) fr.push_back(8'($urandom_range(0, 255)));
      x = 8'h00;
      foreach (fr[i]) x = x ^ fr[i];
      if (corrupt) x = x ^ (8'h01 << $urandom_range(0, 7));
      fr.push_back(x);
      return fr;
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Present one byte, wait for it to be taken, then check the write cycle.
   task automatic send_byte(input logic [7:0] b, input int gap, input bit payload,
                            input int idx, input bit mid_start);
      int n;
      n = 0;
      if (gap > 0) begin
         byte_valid = 1'b0;
         if (mid_start) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         repeat (gap - 1) @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_data  = b;
      while (byte_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      tests_run++;
      if (n >= 50) begin
         tests_failed++;
         $display("FAIL accept_timeout idx=%0d byte_ready=%b required 1", idx, byte_ready);
         byte_valid = 1'b0;
         return;
      end
      @(negedge clk);
      tests_run++;
      if (wr_en !== payload) begin
         tests_failed++;
         $display("FAIL wr_en_latency idx=%0d got %b required %b", idx, wr_en, payload);
      end
      if (payload) begin
         tests_run++;
         if (wr_addr !== 10'(idx) || wr_data !== b) begin
            tests_failed++;
            $display("FAIL write idx=%0d got addr %0d data %h required addr %0d data %h",
                     idx, wr_addr, wr_data, idx, b);
         end
         tests_run++;
         if (words_loaded !== 16'((idx + 1) / 4)) begin
            tests_failed++;
            $display("FAIL words_running idx=%0d got %0d required %0d",
                     idx, words_loaded, (idx + 1) / 4);
         end
      end
   endtask

   // gap < 0 selects a random gap of 0..2 idle cycles before each byte.
   task automatic run_frame(input bq_t fr, input int gap, input bit mid_start, input string name);
      int n, err, nwr, nsend, w0, g;
      bit pay;
      model(fr, n, err, nwr);
      nsend = (err == 1) ? 2 : 3 + 4 * n;
      pulse_start();
      w0 = wr_cycles;
      for (int i = 0; i < nsend; i++) begin
         g = (gap < 0) ? $urandom_range(0, 2) : ((i == 0) ? 0 : gap);
         pay = (i >= 2) && (i < 2 + 4 * n);
         send_byte(fr[i], g, pay, i - 2, mid_start && (i == 5) && (g > 0));
      end
      byte_valid = 1'b0;
      tests_run++;
      if (done !== (err == 0) || err_code !== 2'(err) || cpu_hold !== (err != 0)) begin
         tests_failed++;
         $display("FAIL %s_status got done=%b err=%0d hold=%b required done=%b err=%0d hold=%b",
                  name, done, err_code, cpu_hold, err == 0, err, err != 0);
      end
      tests_run++;
      if (busy !== 1'b0 || byte_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s_idle got busy=%b ready=%b required 0 0", name, busy, byte_ready);
      end
      tests_run++;
      if (words_loaded !== ((err == 1) ? 16'd0 : 16'(n)) || (wr_cycles - w0) != nwr) begin
         tests_failed++;
         $display("FAIL %s_count got words=%0d writes=%0d required words=%0d writes=%0d",
                  name, words_loaded, wr_cycles - w0, (err == 1) ? 0 : n, nwr);
      end
   endtask

   function automatic bq_t nominal(input logic [7:0] csum);
      bq_t fr;
      fr = '{8'h00, 8'h02, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h01, 8'h13};
      fr.push_back(csum);
      return fr;
   endfunction

   task automatic test_reset();
      repeat (2) @(negedge clk);
      tests_run++;
      if (byte_ready !== 0 || wr_en !== 0 || wr_addr !== 0 || wr_data !== 0 ||
          words_loaded !== 0 || busy !== 0 || done !== 0 || err_code !== 0 || cpu_hold !== 1) begin
         tests_failed++;
         $display("FAIL reset_values got rdy=%b we=%b a=%0d d=%h w=%0d busy=%b done=%b err=%0d hold=%b required 0 0 0 00 0 0 0 0 1",
                  byte_ready, wr_en, wr_addr, wr_data, words_loaded, busy, done, err_code, cpu_hold);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_nominal();
      run_frame(nominal(8'hB3), 0, 1'b0, "nominal");
   endtask

   task automatic test_bad_csum();
      run_frame(nominal(8'hB2), 0, 1'b0, "bad_csum");
   endtask

   task automatic test_overflow();
      bq_t fr;
      int w0;
      fr = '{8'h01, 8'h01, 8'h00};
      run_frame(fr, 0, 1'b0, "overflow");
      w0 = wr_cycles;
      byte_valid = 1'b1;
      byte_data  = 8'h55;
      repeat (3) @(negedge clk);
      byte_valid = 1'b0;
      tests_run++;
      if (byte_ready !== 1'b0 || err_code !== 2'd1 || wr_cycles != w0) begin
         tests_failed++;
         $display("FAIL overflow_stuck got ready=%b err=%0d writes=%0d required 0 1 0",
                  byte_ready, err_code, wr_cycles - w0);
      end
      pulse_start();
      tests_run++;
      if (busy !== 1'b1 || byte_ready !== 1'b1 || err_code !== 2'd0) begin
         tests_failed++;
         $display("FAIL overflow_restart got busy=%b ready=%b err=%0d required 1 1 0",
                  busy, byte_ready, err_code);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_zero_len();
      bq_t fr;
      fr = '{8'h00, 8'h00, 8'h00};
      run_frame(fr, 0, 1'b0, "zero_len");
   endtask

   task automatic test_back_to_back();
      run_frame(nominal(8'hB3), 3, 1'b1, "backpressure");
      run_frame(nominal(8'hB3), 0, 1'b0, "full_rate");
   endtask

   task automatic test_reset_midframe();
      bq_t fr;
      fr = nominal(8'hB3);
      pulse_start();
      for (int i = 0; i < 7; i++) send_byte(fr[i], 0, i >= 2, i - 2, 1'b0);
      byte_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      tests_run++;
      if (byte_ready !== 0 || wr_en !== 0 || wr_addr !== 0 || wr_data !== 0 ||
          words_loaded !== 0 || busy !== 0 || done !== 0 || err_code !== 0 || cpu_hold !== 1) begin
         tests_failed++;
         $display("FAIL midframe_reset got rdy=%b we=%b a=%0d d=%h w=%0d busy=%b done=%b err=%0d hold=%b required 0 0 0 00 0 0 0 0 1",
                  byte_ready, wr_en, wr_addr, wr_data, words_loaded, busy, done, err_code, cpu_hold);
      end
      rst_n = 1'b1;
      @(negedge clk);
      run_frame(fr, 0, 1'b0, "after_reset");
   endtask

   task automatic test_random();
      int n;
      for (int k = 0; k < 12; k++) begin
         if ($urandom_range(0, 5) == 0) begin
            n = $urandom_range(257, 2000);
            run_frame(make_frame(0, 1'b0), -1, 1'b0, "rand_zero");
            begin
               bq_t fr;
               logic [15:0] n16;
               n16 = 16'(n);
               fr = '{n16[15:8], n16[7:0], 8'h00};
               run_frame(fr, -1, 1'b0, "rand_ovf");
            end
         end else begin
            n = $urandom_range(1, 12);
            run_frame(make_frame(n, $urandom_range(0, 3) == 0), -1, 1'b0, "rand");
         end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_bad_csum();
      test_overflow();
      test_zero_len();
      test_back_to_back();
      test_reset_midframe();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader: the writer side of the byte-addressed, big-endian instruction memory that the fetch path reads.
- Receives a framed byte stream over a valid/ready handshake, e.g. from a UART RX or the testbench.
- Writes payload bytes into the instruction memory's byte write port, in stream order, from address BASE_ADDR.
- Holds the core in reset until a frame loads and its checksum verifies.

Parameters:
- MEM_BYTES, 1024: instruction memory size in bytes.
- ADDR_W, 10: byte address width; must satisfy 2**ADDR_W >= MEM_BYTES.
- BASE_ADDR, 0: first byte address written.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle pulse; begins a load. Honoured only in IDLE, DONE or ERR.
- byte_valid  in  1  stream byte present.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts byte_data this cycle.
- wr_en  out  1  instruction memory byte write strobe.
- wr_addr  out  ADDR_W  byte address.
- wr_data  out  8  byte to write.
- words_loaded  out  16  complete 32-bit words written in the current frame.
- busy  out  1  frame in progress.
- done  out  1  last frame loaded and verified.
- err_code  out  2  0 = none, 1 = length overflow, 2 = checksum mismatch.
- cpu_hold  out  1  core reset request.

Behaviour:
- Frame format: LEN_HI, LEN_LO, then 4*N payload bytes, then CSUM.
  - N is a 16-bit big-endian word count.
  - Payload bytes are in memory order, so word bytes are MSB first.
  - CSUM is the XOR of every preceding frame byte, header included.
- A byte is accepted when byte_valid && byte_ready.
- byte_ready is high only in LEN_HI, LEN_LO, DATA and CSUM. It is a registered state decode, not dependent on byte_valid.
- Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, words_loaded=0, busy=0, done=0, err_code=0, cpu_hold=1. State=IDLE. Internal byte index and running checksum are 0.
- States:
  - IDLE: start -> LEN_HI. Clears the index, checksum, words_loaded, done and err_code.
  - LEN_HI: on accept, latch N[15:8] -> LEN_LO.
  - LEN_LO: on accept, latch N[7:0], then:
    - N == 0 -> CSUM.
    - 4*N > MEM_BYTES - BASE_ADDR -> ERR with err_code=1, and no byte is ever written.
    - otherwise -> DATA.
  - DATA: each accepted byte is written. Once the 4*N-th byte is accepted -> CSUM.
  - CSUM: on accept, compare against the running checksum. Match -> DONE. Mismatch -> ERR with err_code=2.
  - DONE: done=1, cpu_hold=0. start -> LEN_HI with cpu_hold=1 again.
  - ERR: cpu_hold stays 1. start -> LEN_HI.
- Write latency: a DATA byte accepted in cycle t drives wr_en=1, wr_addr=BASE_ADDR+index and wr_data=byte in cycle t+1. wr_en lasts exactly one cycle per byte.
- Index arithmetic: the index counts 0 .. 4N-1 and is truncated to ADDR_W. The overflow check guarantees no wrap.
- words_loaded increments in the write cycle of every 4th byte, i.e. index[1:0]==3.
- busy is 1 in LEN_HI through CSUM.
- cpu_hold is 1 in every state except DONE.
- start is ignored while busy.
- Back-to-back accepts at full rate must work, one byte per cycle. Gaps in byte_valid only stall progress.
- Bytes arriving while byte_ready=0 are not consumed.
- Reset mid-frame aborts the frame:
  - Bytes already written stay in memory.
  - All outputs return to their reset values.
  - The next start reloads from BASE_ADDR.
- A memory image is valid only when done=1. After ERR the memory contents are undefined.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum loader_state_t {L_IDLE, L_LEN_HI, L_LEN_LO, L_DATA, L_CSUM, L_DONE, L_ERR};
  - err_code constants ERR_NONE=0, ERR_LEN=1, ERR_CSUM=2;
  - constant IMEM_BYTES=1024.
- No sub-module: a single FSM plus index/checksum counters. The instruction memory gains a matching byte write port in a separate change.

Test Plan:
- Nominal load:
  - Stimulus: start, then 00 02 | 00 10 00 93 00 20 01 13 | B3.
  - Response: writes to addr 0..7 with data 00,10,00,93,00,20,01,13; words_loaded=2; done=1; cpu_hold=0; err_code=0.
- Bad checksum:
  - Stimulus: same frame with last byte B2.
  - Response: all 8 writes occur; then err_code=2, done=0, cpu_hold=1, byte_ready=0.
- Length overflow (MEM_BYTES=1024):
  - Stimulus: header 01 01 (257 words).
  - Response: ERR with err_code=1 right after LEN_LO, zero wr_en pulses, byte_ready=0; a following start returns to LEN_HI.
- Zero length:
  - Stimulus: 00 00 | 00.
  - Response: no writes, words_loaded=0, done=1, cpu_hold=0.
- Backpressure and full rate:
  - Stimulus: the nominal frame with byte_valid low for 3 cycles between every byte, then again with byte_valid continuously high.
  - Response: identical write sequence in both cases; each wr_en exactly 1 cycle after its accept; a start pulse issued mid-frame is ignored.
- Reset mid-frame:
  - Stimulus: rst_n low for 1 cycle after the 5th payload byte.
  - Response: next cycle shows all reset values (cpu_hold=1, busy=0); a new start plus the nominal frame writes again from addr 0 and ends in done=1.
